ctrl_decode_queue: RTL and testbench

Registered decode stage between fetch and issue. Each instruction word and its PC are decoded into the control bundle at enqueue and written into a DEPTH-entry FIFO. The FIFO drives issue over valid/ready handshakes and supports pipeline flush. Successor to the purely combinational control unit: it adds buffering, backpressure, a parametrised PC width and depth, and register-index extraction.

---
 rtl/ctrl_pkg.sv | 97 +++++++++
 rtl/ctrl_decode_logic.sv | 134 +++++++++++++
 rtl/ctrl_decode_queue.sv | 158 +++++++++++++++
 tb/tb_ctrl_decode_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode definitions: opcodes, field widths, control bundle layout
// and exception codes used by the decode logic and the decode queue.
package ctrl_pkg;

    localparam int INST_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int RES_SRC_W = 2;
    localparam int ALU_OP_W  = 4;
    localparam int LSU_OP_W  = 5;
    localparam int ALU_SRC_W = 4;
    localparam int IMM_SRC_W = 3;
    localparam int CSR_OP_W  = 3;
    localparam int EXC_W     = 4;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;

    localparam logic [RES_SRC_W-1:0] RES_ALU = 2'd0;
    localparam logic [RES_SRC_W-1:0] RES_MEM = 2'd1;
    localparam logic [RES_SRC_W-1:0] RES_PC4 = 2'd2;
    localparam logic [RES_SRC_W-1:0] RES_CSR = 2'd3;

    localparam logic [ALU_SRC_W-1:0] SRC1_RS1  = 4'd0;
    localparam logic [ALU_SRC_W-1:0] SRC1_PC   = 4'd1;
    localparam logic [ALU_SRC_W-1:0] SRC1_ZERO = 4'd2;
    localparam logic [ALU_SRC_W-1:0] SRC1_UIMM = 4'd3;
    localparam logic [ALU_SRC_W-1:0] SRC2_RS2  = 4'd0;
    localparam logic [ALU_SRC_W-1:0] SRC2_IMM  = 4'd1;
    localparam logic [ALU_SRC_W-1:0] SRC2_FOUR = 4'd2;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'd4;

    typedef enum logic [EXC_W-1:0] {
        EXC_NONE    = 4'd0,
        EXC_ILLEGAL = 4'd2,
        EXC_BREAK   = 4'd3,
        EXC_ECALL   = 4'd11
    } exc_e;

    // 34 bits of control; field order is fixed so entries pack predictably.
    typedef struct packed {
        logic                 is_branch;
        logic                 is_jump;
        logic                 imm_sign;
        logic                 reg_wr_en;
        logic                 pc_add_reg;
        logic [RES_SRC_W-1:0] result_src;
        logic [ALU_OP_W-1:0]  alu_op_sel;
        logic [LSU_OP_W-1:0]  lsu_op;
        logic [ALU_SRC_W-1:0] alu_src1;
        logic [ALU_SRC_W-1:0] alu_src2;
        logic [IMM_SRC_W-1:0] imm_src;
        logic [CSR_OP_W-1:0]  csr_op;
        exc_e                 exc_type;
    } ctrl_bundle_t;

    function automatic logic [ALU_OP_W-1:0] alu_op_from_funct(input logic [2:0] funct3,
                                                              input logic       alt);
        logic [ALU_OP_W-1:0] op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode_logic.sv
// Combinational instruction decoder: 32-bit instruction word to control bundle.
// Any encoding it does not recognise yields EXC_ILLEGAL with all controls cleared.
module ctrl_decode_logic
    import ctrl_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output ctrl_bundle_t      ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl.reg_wr_en  = 1'b1;
                ctrl.alu_op_sel = ALU_PASSB;
                ctrl.alu_src1   = SRC1_ZERO;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_U;
                ctrl.imm_sign   = inst[31];
            end
            OP_AUIPC: begin
                ctrl.reg_wr_en  = 1'b1;
                ctrl.alu_op_sel = ALU_ADD;
                ctrl.alu_src1   = SRC1_PC;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_U;
                ctrl.imm_sign   = inst[31];
            end
            OP_JAL: begin
                ctrl.is_jump    = 1'b1;
                ctrl.reg_wr_en  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_op_sel = ALU_ADD;
                ctrl.alu_src1   = SRC1_PC;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_J;
                ctrl.imm_sign   = inst[31];
            end
            OP_JALR: begin
                ctrl.is_jump    = 1'b1;
                ctrl.pc_add_reg = 1'b1;
                ctrl.reg_wr_en  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_op_sel = ALU_ADD;
                ctrl.alu_src1   = SRC1_RS1;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.imm_sign   = inst[31];
                illegal         = (funct3 != 3'd0);
            end
            OP_BRANCH: begin
                // Compare on the ALU; the target adder is fed from pc + imm separately.
                ctrl.is_branch  = 1'b1;
                ctrl.alu_op_sel = (funct3[2:1] == 2'b00) ? ALU_SUB :
                                  (funct3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
                ctrl.alu_src1   = SRC1_RS1;
                ctrl.alu_src2   = SRC2_RS2;
                ctrl.imm_src    = IMM_B;
                ctrl.imm_sign   = inst[31];
                illegal         = (funct3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                ctrl.reg_wr_en  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_op_sel = ALU_ADD;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.imm_sign   = inst[31];
                ctrl.lsu_op     = {1'b1, 1'b0, funct3};
                illegal         = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                ctrl.alu_op_sel = ALU_ADD;
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_S;
                ctrl.imm_sign   = inst[31];
                ctrl.lsu_op     = {1'b1, 1'b1, funct3};
                illegal         = (funct3[2] || funct3 == 3'd3);
            end
            OP_IMM: begin
                ctrl.reg_wr_en  = 1'b1;
                ctrl.alu_op_sel = alu_op_from_funct(funct3, inst[30] && (funct3 == 3'd5));
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.imm_sign   = inst[31];
                if (funct3 == 3'd1)
                    illegal = (funct7 != 7'h00);
                else if (funct3 == 3'd5)
                    illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OP_REG: begin
                ctrl.reg_wr_en  = 1'b1;
                ctrl.alu_op_sel = alu_op_from_funct(funct3, inst[30]);
                illegal         = !((funct7 == 7'h00) ||
                                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
            end
            OP_SYSTEM: begin
                if (funct3 == 3'd0) begin
                    if (inst[31:7] == 25'h0)
                        ctrl.exc_type = EXC_ECALL;
                    else if (inst[31:7] == 25'h2000)
                        ctrl.exc_type = EXC_BREAK;
                    else
                        illegal = 1'b1;
                end else if (funct3 == 3'd4) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.reg_wr_en  = 1'b1;
                    ctrl.result_src = RES_CSR;
                    ctrl.csr_op     = funct3;
                    ctrl.alu_src1   = funct3[2] ? SRC1_UIMM : SRC1_RS1;
                    ctrl.imm_src    = IMM_I;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl          = '0;
            ctrl.exc_type = EXC_ILLEGAL;
        end
    end

endmodule

// File: rtl/ctrl_decode_queue.sv
// Registered decode stage: decodes at enqueue into a DEPTH-entry FIFO drained by issue.
// Optional performance counters are built only when CTRL_DECODE_PERF_EN is defined.
module ctrl_decode_queue
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_flush,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [INST_W-1:0]    io_in_inst,
    input  logic [XLEN-1:0]      io_in_pc,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [XLEN-1:0]      io_out_pc,
    output logic [REG_IDX_W-1:0] io_out_rd,
    output logic [REG_IDX_W-1:0] io_out_rs1,
    output logic [REG_IDX_W-1:0] io_out_rs2,
    output logic                 io_out_isBranch,
    output logic                 io_out_isJump,
    output logic                 io_out_immSign,
    output logic                 io_out_regWrEn,
    output logic                 io_out_pcAddReg,
    output logic [RES_SRC_W-1:0] io_out_resultSrc,
    output logic [ALU_OP_W-1:0]  io_out_aluOpSel,
    output logic [LSU_OP_W-1:0]  io_out_lsuOp,
    output logic [ALU_SRC_W-1:0] io_out_aluSrc1,
    output logic [ALU_SRC_W-1:0] io_out_aluSrc2,
    output logic [IMM_SRC_W-1:0] io_out_immSrc,
    output logic [CSR_OP_W-1:0]  io_out_csrOp,
    output logic [EXC_W-1:0]     io_out_excType,
    output logic [CNT_W-1:0]     io_perf_decoded,
    output logic [CNT_W-1:0]     io_perf_stall
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        ctrl_bundle_t         ctrl;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [XLEN-1:0]      pc;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    ctrl_bundle_t     dec_ctrl;
    logic [PTR_W-1:0] rptr_reg, rptr_next;
    logic [PTR_W-1:0] wptr_reg, wptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             enq;
    logic             deq;

    ctrl_decode_logic u_decode (
        .inst (io_in_inst),
        .ctrl (dec_ctrl)
    );

    assign wr_entry = '{ctrl: dec_ctrl,
                        rd:   io_in_inst[11:7],
                        rs1:  io_in_inst[19:15],
                        rs2:  io_in_inst[24:20],
                        pc:   io_in_pc};

    // Ready comes from registered occupancy only, so a full queue never passes through.
    assign io_in_ready  = (count_reg != FULL_CNT);
    assign io_out_valid = (count_reg != '0);
    assign enq          = io_in_valid && io_in_ready;
    assign deq          = io_out_valid && io_out_ready;

    always_comb begin
        rptr_next  = rptr_reg;
        wptr_next  = wptr_reg;
        count_next = count_reg;
        if (io_flush) begin
            rptr_next  = '0;
            wptr_next  = '0;
            count_next = '0;
        end else begin
            if (enq)
                wptr_next = wptr_reg + PTR_W'(1);
            if (deq)
                rptr_next = rptr_reg + PTR_W'(1);
            if (enq && !deq)
                count_next = count_reg + (PTR_W + 1)'(1);
            else if (!enq && deq)
                count_next = count_reg - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (enq && !io_flush)
            mem[wptr_reg] <= wr_entry;
    end

    assign head             = mem[rptr_reg];
    assign io_out_pc        = head.pc;
    assign io_out_rd        = head.rd;
    assign io_out_rs1       = head.rs1;
    assign io_out_rs2       = head.rs2;
    assign io_out_isBranch  = head.ctrl.is_branch;
    assign io_out_isJump    = head.ctrl.is_jump;
    assign io_out_immSign   = head.ctrl.imm_sign;
    assign io_out_regWrEn   = head.ctrl.reg_wr_en;
    assign io_out_pcAddReg  = head.ctrl.pc_add_reg;
    assign io_out_resultSrc = head.ctrl.result_src;
    assign io_out_aluOpSel  = head.ctrl.alu_op_sel;
    assign io_out_lsuOp     = head.ctrl.lsu_op;
    assign io_out_aluSrc1   = head.ctrl.alu_src1;
    assign io_out_aluSrc2   = head.ctrl.alu_src2;
    assign io_out_immSrc    = head.ctrl.imm_src;
    assign io_out_csrOp     = head.ctrl.csr_op;
    assign io_out_excType   = head.ctrl.exc_type;

`ifdef CTRL_DECODE_PERF_EN
    logic [CNT_W-1:0] perf_decoded_reg;
    logic [CNT_W-1:0] perf_stall_reg;

    // Counters survive flush; a handshake during flush still counts as decoded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_decoded_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (enq)
                perf_decoded_reg <= perf_decoded_reg + CNT_W'(1);
            if (io_in_valid && !io_in_ready)
                perf_stall_reg <= perf_stall_reg + CNT_W'(1);
        end
    end

    assign io_perf_decoded = perf_decoded_reg;
    assign io_perf_stall   = perf_stall_reg;
`else
    assign io_perf_decoded = '0;
    assign io_perf_stall   = '0;
`endif

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Scoreboard bench for ctrl_decode_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares on every output handshake.
module tb_ctrl_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;
`ifdef CTRL_DECODE_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_flush = 1'b0;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [31:0]      io_in_inst = '0;
    logic [XLEN-1:0]  io_in_pc = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [XLEN-1:0]  io_out_pc;
    logic [4:0]       io_out_rd, io_out_rs1, io_out_rs2;
    logic             io_out_isBranch, io_out_isJump, io_out_immSign;
    logic             io_out_regWrEn, io_out_pcAddReg;
    logic [1:0]       io_out_resultSrc;
    logic [3:0]       io_out_aluOpSel;
    logic [4:0]       io_out_lsuOp;
    logic [3:0]       io_out_aluSrc1, io_out_aluSrc2;
    logic [2:0]       io_out_immSrc, io_out_csrOp;
    logic [3:0]       io_out_excType;
    logic [CNT_W-1:0] io_perf_decoded, io_perf_stall;

    ctrl_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_inst(io_in_inst), .io_in_pc(io_in_pc),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_pc(io_out_pc), .io_out_rd(io_out_rd), .io_out_rs1(io_out_rs1),
        .io_out_rs2(io_out_rs2), .io_out_isBranch(io_out_isBranch),
        .io_out_isJump(io_out_isJump), .io_out_immSign(io_out_immSign),
        .io_out_regWrEn(io_out_regWrEn), .io_out_pcAddReg(io_out_pcAddReg),
        .io_out_resultSrc(io_out_resultSrc), .io_out_aluOpSel(io_out_aluOpSel),
        .io_out_lsuOp(io_out_lsuOp), .io_out_aluSrc1(io_out_aluSrc1),
        .io_out_aluSrc2(io_out_aluSrc2), .io_out_immSrc(io_out_immSrc),
        .io_out_csrOp(io_out_csrOp), .io_out_excType(io_out_excType),
        .io_perf_decoded(io_perf_decoded), .io_perf_stall(io_perf_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic        br, jmp, pcadd, wr, exc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done;

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic br, input logic jmp,
                                input logic pcadd, input logic wr, input logic exc);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.br = br; e.jmp = jmp; e.pcadd = pcadd; e.wr = wr; e.exc = exc;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && io_out_valid && io_out_ready && !io_flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc 0x%0h, required no output", io_out_pc);
            end else begin
                e = exp_q.pop_front();
                $display("deq pc=0x%08h rd=%0d rs1=%0d rs2=%0d br=%0b jmp=%0b pcadd=%0b wr=%0b exc=%0d",
                         io_out_pc, io_out_rd, io_out_rs1, io_out_rs2, io_out_isBranch,
                         io_out_isJump, io_out_pcAddReg, io_out_regWrEn, io_out_excType);
                check("out_pc", io_out_pc, e.pc);
                check("out_rd", io_out_rd, e.rd);
                check("out_rs1", io_out_rs1, e.rs1);
                check("out_rs2", io_out_rs2, e.rs2);
                check("out_isBranch", io_out_isBranch, e.br);
                check("out_isJump", io_out_isJump, e.jmp);
                check("out_pcAddReg", io_out_pcAddReg, e.pcadd);
                check("out_regWrEn", io_out_regWrEn, e.wr);
                check("out_exc_nonzero", io_out_excType != 4'd0, e.exc);
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        bit done = 0;
        io_in_valid = 1'b1;
        io_in_inst  = inst;
        io_in_pc    = pc;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (io_in_ready) begin
                exp_q.push_back(e);
                done = 1;
                $display("enq pc=0x%08h inst=0x%08h", pc, inst);
            end
            @(posedge clock);
            #1;
        end
        io_in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 for 20 cycles, required accept of pc 0x%0h", pc);
        end
    endtask

    task automatic drain();
        io_out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        #12;
        check("reset_out_valid", io_out_valid, 0);
        check("reset_in_ready", io_in_ready, 1);
        check("reset_perf_decoded", io_perf_decoded, 0);
        check("reset_perf_stall", io_perf_stall, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Fill with issue stalled: two accepts, then two stall cycles.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            io_in_inst = 32'h13 | ((c + 1) << 7) | ((c + 1) << 20);
            io_in_pc   = 32'h100 + 4 * c;
            @(negedge clock);
            check("fill_in_ready", io_in_ready, (c < 2) ? 1 : 0);
            if (io_in_ready) begin
                exp_q.push_back(mk(32'h100 + 4 * c, 5'(c + 1), 5'd0, 5'(c + 1), 0, 0, 0, 1, 0));
                $display("enq pc=0x%08h inst=0x%08h", io_in_pc, io_in_inst);
            end
            @(posedge clock);
            #1;
        end
        io_in_valid = 1'b0;
        @(negedge clock);
        check("full_out_valid", io_out_valid, 1);
        check("fill_perf_decoded", io_perf_decoded, (PERF != 0) ? 2 : 0);
        check("fill_perf_stall", io_perf_stall, (PERF != 0) ? 2 : 0);
        @(posedge clock);
        #1;
        drain();

        // addi x1,x0,5 appears exactly one cycle after acceptance.
        check("empty_out_valid", io_out_valid, 0);
        send(32'h00500093, 32'h80000000, mk(32'h80000000, 5'd1, 5'd0, 5'd5, 0, 0, 0, 1, 0));
        check("latency_out_valid", io_out_valid, 1);
        drain();

        send(32'h000080E7, 32'h2000, mk(32'h2000, 5'd1, 5'd1, 5'd0, 0, 1, 1, 1, 0));
        send(32'h0000006F, 32'h2004, mk(32'h2004, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0));
        drain();

        send(32'h00208133, 32'h3000, mk(32'h3000, 5'd2, 5'd1, 5'd2, 0, 0, 0, 1, 0));
        send(32'h0020A223, 32'h3004, mk(32'h3004, 5'd4, 5'd1, 5'd2, 0, 0, 0, 0, 0));
        send(32'h00208063, 32'h3008, mk(32'h3008, 5'd0, 5'd1, 5'd2, 1, 0, 0, 0, 0));
        send(32'h0000000B, 32'h300C, mk(32'h300C, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1));
        send(32'h00000073, 32'h3010, mk(32'h3010, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1));
        drain();

        // Flush a full queue while both handshakes are offered.
        io_out_ready = 1'b0;
        send(32'h00100093, 32'h4000, mk(32'h4000, 5'd1, 5'd0, 5'd1, 0, 0, 0, 1, 0));
        send(32'h00200113, 32'h4004, mk(32'h4004, 5'd2, 5'd0, 5'd2, 0, 0, 0, 1, 0));
        io_in_valid  = 1'b1;
        io_in_inst   = 32'h00700393;
        io_in_pc     = 32'hDEAD0000;
        io_flush     = 1'b1;
        io_out_ready = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("flush_cycle_in_ready", io_in_ready, 0);
        @(posedge clock);
        #1;
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        @(negedge clock);
        check("post_flush_out_valid", io_out_valid, 0);
        check("post_flush_in_ready", io_in_ready, 1);
        repeat (4) @(posedge clock);
        #1;
        send(32'h00900493, 32'h4100, mk(32'h4100, 5'd9, 5'd0, 5'd9, 0, 0, 0, 1, 0));
        drain();

        // Ten-instruction stream against toggling issue readiness.
        stim_done = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(32'h13 | (i << 7) | (i << 20), 32'h1000 + 4 * i,
                         mk(32'h1000 + 4 * i, 5'(i), 5'd0, 5'(i), 0, 0, 0, 1, 0));
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clock);
                    #1;
                    io_out_ready = ~io_out_ready;
                end
            end
        join
        drain();

        // Reset asserted with one buffered entry clears state without a clock edge.
        io_out_ready = 1'b0;
        send(32'h00A00513, 32'h5000, mk(32'h5000, 5'd10, 5'd0, 5'd10, 0, 0, 0, 1, 0));
        @(negedge clock);
        check("pre_reset_out_valid", io_out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_out_valid", io_out_valid, 0);
        check("async_reset_in_ready", io_in_ready, 1);
        check("async_reset_perf_decoded", io_perf_decoded, 0);
        check("async_reset_perf_stall", io_perf_stall, 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_out_valid", io_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
